// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline-control types: forwarding selects, hazard FSM states and the
// stall/flush command bundle consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers.
package hazard_ctrl_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        REG = 2'b00,
        WB  = 2'b01,
        MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RUN    = 2'b00,
        DRAIN  = 2'b01,
        HALTED = 2'b10
    } hz_state_e;

    typedef struct packed {
        logic stall_pc;
        logic stall_if_id;
        logic stall_id_ex;
        logic stall_ex_mem;
        logic flush_if_id;
        logic flush_id_ex;
        logic flush_mem_wb;
    } hz_cmd_t;

    localparam hz_cmd_t CMD_NONE     = 7'b0000_000;
    localparam hz_cmd_t CMD_RESET    = 7'b0000_111;
    localparam hz_cmd_t CMD_MEM_BUSY = 7'b1111_001;
    localparam hz_cmd_t CMD_BRANCH   = 7'b0000_110;
    localparam hz_cmd_t CMD_LOAD_USE = 7'b1100_010;
    localparam hz_cmd_t CMD_DRAIN    = 7'b1000_100;
    localparam hz_cmd_t CMD_HALTED   = 7'b1111_000;

    // x0 is hard-wired zero, so a write to it never produces a usable result.
    function automatic logic writes_reg(input logic regwrite,
                                        input logic [REG_AW-1:0] rd,
                                        input logic [REG_AW-1:0] src);
        return regwrite && (rd != '0) && (rd == src);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-register view seen by hazard_ctrl: buffer-register fields in,
// stall/flush/forward commands and status out.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    import hazard_ctrl_pkg::*;

    logic [4:0] if_id_rs1;
    logic [4:0] if_id_rs2;
    logic       id_ex_memread;
    logic [4:0] id_ex_rd;
    logic       id_ex_halt;
    logic [4:0] id_ex_rs1;
    logic [4:0] id_ex_rs2;
    logic       ex_pc_sel;
    logic       ex_mem_regwrite;
    logic [4:0] ex_mem_rd;
    logic       mem_wb_regwrite;
    logic [4:0] mem_wb_rd;
    logic       mem_busy;

    // Commands are combinational and take effect on the next rising edge:
    // a stall holds the register, a flush loads a bubble on that edge.
    logic       stall_pc;
    logic       stall_if_id;
    logic       stall_id_ex;
    logic       stall_ex_mem;
    logic       flush_if_id;
    logic       flush_id_ex;
    logic       flush_mem_wb;
    hz_cmd_t    cmd;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;
    logic       halted;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    hz_state_e  state;

    modport master (
        output if_id_rs1, if_id_rs2, id_ex_memread, id_ex_rd, id_ex_halt,
               id_ex_rs1, id_ex_rs2, ex_pc_sel, ex_mem_regwrite, ex_mem_rd,
               mem_wb_regwrite, mem_wb_rd, mem_busy,
        input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_mem_wb, cmd,
               fwd_a, fwd_b, halted, stall_cnt, flush_cnt, state
    );

    modport slave (
        input  if_id_rs1, if_id_rs2, id_ex_memread, id_ex_rd, id_ex_halt,
               id_ex_rs1, id_ex_rs2, ex_pc_sel, ex_mem_regwrite, ex_mem_rd,
               mem_wb_regwrite, mem_wb_rd, mem_busy,
        output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
               flush_if_id, flush_id_ex, flush_mem_wb, cmd,
               fwd_a, fwd_b, halted, stall_cnt, flush_cnt, state
    );

endinterface

// File: rtl/hazard_ctrl_forwarding_unit.sv
// Picks the freshest source for one EX operand; the younger EX/MEM result
// takes precedence over MEM/WB when both target the same register.
module forwarding_unit
    import hazard_ctrl_pkg::*;
(
    input  logic        ex_mem_regwrite,
    input  logic [4:0]  ex_mem_rd,
    input  logic        mem_wb_regwrite,
    input  logic [4:0]  mem_wb_rd,
    input  logic [4:0]  src,
    output fwd_sel_e    sel
);

    always_comb begin
        sel = REG;
        if (writes_reg(mem_wb_regwrite, mem_wb_rd, src)) begin
            sel = WB;
        end
        if (writes_reg(ex_mem_regwrite, ex_mem_rd, src)) begin
            sel = MEM;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: stall/flush commands, EX forwarding selects,
// halt drain sequencing and saturating stall/flush event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int DRAIN_CYC = 3
) (
    input  logic      clk,
    input  logic      reset,
    hazard_ctrl_if.slave hz
);

    localparam int DCNT_W = $clog2(DRAIN_CYC + 1);

    hz_state_e         state;
    logic [DCNT_W-1:0] drain_cnt;
    logic              halted_q;
    logic [CNT_W-1:0]  stall_cnt_q;
    logic [CNT_W-1:0]  flush_cnt_q;
    hz_cmd_t           cmd;
    logic              load_use;
    logic              take_branch;
    logic              enter_drain;
    fwd_sel_e          sel_a;
    fwd_sel_e          sel_b;

    forwarding_unit u_fwd_a (
        .ex_mem_regwrite (hz.ex_mem_regwrite),
        .ex_mem_rd       (hz.ex_mem_rd),
        .mem_wb_regwrite (hz.mem_wb_regwrite),
        .mem_wb_rd       (hz.mem_wb_rd),
        .src             (hz.id_ex_rs1),
        .sel             (sel_a)
    );

    forwarding_unit u_fwd_b (
        .ex_mem_regwrite (hz.ex_mem_regwrite),
        .ex_mem_rd       (hz.ex_mem_rd),
        .mem_wb_regwrite (hz.mem_wb_regwrite),
        .mem_wb_rd       (hz.mem_wb_rd),
        .src             (hz.id_ex_rs2),
        .sel             (sel_b)
    );

    assign load_use = hz.id_ex_memread && (hz.id_ex_rd != '0) &&
                      ((hz.id_ex_rd == hz.if_id_rs1) || (hz.id_ex_rd == hz.if_id_rs2));

    // A taken branch only counts as a flush when a busy memory is not freezing the pipe.
    assign take_branch = (state == RUN) && !hz.mem_busy && hz.ex_pc_sel;
    assign enter_drain = (state == RUN) && !hz.mem_busy && !hz.ex_pc_sel && hz.id_ex_halt;

    always_comb begin
        cmd = CMD_NONE;
        if (reset) begin
            cmd = CMD_RESET;
        end else begin
            case (state)
                RUN: begin
                    if (hz.mem_busy) begin
                        cmd = CMD_MEM_BUSY;
                    end else if (hz.ex_pc_sel) begin
                        cmd = CMD_BRANCH;
                    end else if (load_use) begin
                        cmd = CMD_LOAD_USE;
                    end
                end
                DRAIN:   cmd = hz.mem_busy ? CMD_MEM_BUSY : CMD_DRAIN;
                HALTED:  cmd = CMD_HALTED;
                default: cmd = CMD_NONE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            drain_cnt   <= DCNT_W'(DRAIN_CYC);
            halted_q    <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (enter_drain) begin
                        state     <= DRAIN;
                        drain_cnt <= DCNT_W'(DRAIN_CYC);
                    end
                    if (cmd.stall_pc && (stall_cnt_q != '1)) begin
                        stall_cnt_q <= stall_cnt_q + 1'b1;
                    end
                    if (take_branch && (flush_cnt_q != '1)) begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                DRAIN: begin
                    // A busy memory freezes the drain so no retiring instruction is lost.
                    if (!hz.mem_busy) begin
                        if (drain_cnt == DCNT_W'(1)) begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt - 1'b1;
                        end
                    end
                end
                HALTED: begin
                    halted_q <= 1'b1;
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign hz.cmd          = cmd;
    assign hz.stall_pc     = cmd.stall_pc;
    assign hz.stall_if_id  = cmd.stall_if_id;
    assign hz.stall_id_ex  = cmd.stall_id_ex;
    assign hz.stall_ex_mem = cmd.stall_ex_mem;
    assign hz.flush_if_id  = cmd.flush_if_id;
    assign hz.flush_id_ex  = cmd.flush_id_ex;
    assign hz.flush_mem_wb = cmd.flush_mem_wb;
    assign hz.fwd_a        = reset ? REG : sel_a;
    assign hz.fwd_b        = reset ? REG : sel_b;
    assign hz.halted       = halted_q;
    assign hz.stall_cnt    = stall_cnt_q;
    assign hz.flush_cnt    = flush_cnt_q;
    assign hz.state        = state;

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline control for the 5-stage RISC-V core. The IF/ID, ID/EX, EX/MEM and MEM/WB buffer registers carry data forward; this block sends the control back to them. It looks at the buffer registers each cycle and returns four things:
- per-stage stall and flush commands;
- EX-operand forwarding selects;
- halt-drain sequencing, ending in a sticky `halted` flag;
- saturating stall and flush event counters.

## Interface
- `CNT_W`, 16: width of `stall_cnt` and `flush_cnt`.
- `DRAIN_CYC`, 3: cycles from a Halt in EX until the pipeline is empty (EX→MEM→WB→retire).

Ports:
- `clk` in 1: the only clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `if_id_rs1`, `if_id_rs2` in 5 each: source registers decoded from IF/ID `Curr_Instr`.
- `id_ex_memread` in 1, `id_ex_rd` in 5, `id_ex_halt` in 1: from ID/EX.
- `id_ex_rs1`, `id_ex_rs2` in 5 each: from ID/EX.
- `ex_pc_sel` in 1: branch or jump taken, resolved in EX.
- `ex_mem_regwrite` in 1, `ex_mem_rd` in 5: from EX/MEM.
- `mem_wb_regwrite` in 1, `mem_wb_rd` in 5: from MEM/WB.
- `mem_busy` in 1: data memory not ready this cycle.
- `stall_pc`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem` out 1 each: hold the register (write-enable low).
- `flush_if_id`, `flush_id_ex`, `flush_mem_wb` out 1 each: load a bubble (all control bits 0) on the next edge.
- `fwd_a`, `fwd_b` out 2 each: operand source. 00 = register file, 10 = EX/MEM `Alu_Result`, 01 = MEM/WB write-back data.
- `halted` out 1: core stopped.
- `stall_cnt`, `flush_cnt` out CNT_W each: event counters.

## Operation
- **State machine:** states RUN, DRAIN, HALTED.
  - Reset enters RUN, sets the drain counter to DRAIN_CYC, and clears both event counters.
- **Forwarding** (combinational, any state), evaluated for `fwd_a` against `id_ex_rs1` and for `fwd_b` against `id_ex_rs2`:
  - 10 if `ex_mem_regwrite`, `ex_mem_rd`≠0 and `ex_mem_rd` equals the source.
  - Otherwise 01 if the same three conditions hold for the MEM/WB fields.
  - Otherwise 00. EX/MEM wins when both stages match.
- **RUN priority**, highest first:
  1. `mem_busy`: assert `stall_pc`, `stall_if_id`, `stall_id_ex`, `stall_ex_mem` and `flush_mem_wb`; all other commands 0.
  2. `ex_pc_sel`: assert `flush_if_id` and `flush_id_ex`. This overrides any load-use stall in the same cycle.
  3. Load-use hazard, i.e. `id_ex_memread`, `id_ex_rd`≠0, and `id_ex_rd` equals `if_id_rs1` or `if_id_rs2`: assert `stall_pc`, `stall_if_id` and `flush_id_ex`.
  4. Otherwise all commands 0.
- **RUN → DRAIN** when `id_ex_halt`=1 and neither `mem_busy` nor `ex_pc_sel` is set.
- **DRAIN:**
  - Each cycle assert `stall_pc` and `flush_if_id`, so no new instruction enters.
  - Forwarding stays active.
  - The drain counter decrements on each cycle without `mem_busy`. `mem_busy` freezes it and applies the rule-1 pattern.
  - At counter = 1 with no `mem_busy`, move to HALTED.
- **HALTED:** `halted`=1 and all four stall outputs are 1. Only `reset` leaves this state.
- **Counters:**
  - `stall_cnt` increments in each cycle where `stall_pc`=1 in RUN.
  - `flush_cnt` increments in each cycle where `ex_pc_sel` flushes.
  - Both saturate at all-ones and never wrap.

## Timing
- Stall, flush and forwarding outputs are combinational from the inputs and current state, so they act on the next clock edge.
- `halted` is registered. It rises exactly DRAIN_CYC+1 edges after the edge that latched Halt into ID/EX, plus any `mem_busy` cycles during DRAIN.
- Values while `reset` is high:
  - state RUN, `halted`=0, counters 0.
  - `flush_if_id`=`flush_id_ex`=`flush_mem_wb`=1, so bubbles are loaded.
  - all stall outputs 0.
  - `fwd_a`=`fwd_b`=00.
- Reset in the middle of DRAIN returns to RUN immediately, asynchronously.
- A load-use hazard and `mem_busy` together: the `mem_busy` pattern applies. The load-use stall is re-evaluated once `mem_busy` drops.
- `ex_pc_sel` and `id_ex_halt` together: the flush wins. Halt is not entered.

## Structure
- Additions to the shared pipeline buffer package:
  - `fwd_sel_e` enum: REG=00, WB=01, MEM=10.
  - `hz_state_e` enum: RUN, DRAIN, HALTED.
  - `hz_cmd_t` packed struct bundling the seven stall/flush bits, for consumption by the pipeline registers.
- One sub-module, `forwarding_unit`: purely combinational. It takes the EX/MEM and MEM/WB write info plus one source register, and returns one `fwd_sel_e`. It is instantiated twice, for A and B.

## Test plan
- ID/EX load with `id_ex_rd`=5 and `if_id_rs2`=5 → exactly one cycle of `stall_pc`=`stall_if_id`=`flush_id_ex`=1; `stall_cnt` goes 0→1.
- `ex_mem_rd`=7, `mem_wb_rd`=7 (both regwrite) and `id_ex_rs1`=7 → `fwd_a`=10. Repeat with `ex_mem_regwrite`=0 → `fwd_a`=01. Repeat with rd=0 → 00.
- `ex_pc_sel`=1 together with the load-use condition → `flush_if_id`=`flush_id_ex`=1, `stall_pc`=0, `flush_cnt`=1.
- `id_ex_halt`=1 with no `mem_busy` → `halted` rises 4 edges later. Inject `mem_busy` for 2 cycles during DRAIN → `halted` rises 6 edges later.
- Hold the load-use condition for 70000 cycles → `stall_cnt` stops at 65535.
- Assert `reset` while in DRAIN → `halted`=0, all flush outputs 1, state RUN on the next edge after release.
